// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle for the load/store unit: core request/response handshake plus
// the single-port synchronous data-memory port.
// The slave modport is the LSU view; master is the core/memory side.
interface lsu_mem_ctrl_if;
    // Core request channel
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    // Core response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Data memory port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_addr, mem_wdata, mem_rw
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_addr, mem_wdata, mem_rw
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store unit between the core memory stage and a
// single-port synchronous word memory without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-selected and
// sign/zero-extended. One request is outstanding at a time.
// Optional feature macro: LSU_MISALIGN_CHECK_EN
//   defined   : misaligned half/word requests are rejected with rsp_err=1 and
//               make no memory access
//   undefined : low address bits are forced to natural alignment, rsp_err=0
module lsu_mem_ctrl #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32
) (
    input  logic          clk,
    input  logic          reset,
    lsu_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        RMW_WR,
        RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Registered outputs
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_mem_rw;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [31:0]           r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    // Request fields captured at accept
    logic        r_we;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata16;

    logic        w_accept;
    logic        w_is_word;
    logic        w_is_half;
    logic        w_misalign;
    logic [1:0]  w_lane;
    logic [31:0] w_word_addr;
    logic        w_unused_addr;

    // Pick the addressed byte/half of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        if (size[1])
            return word;
        else if (size[0])
            return {{16{~uns & h[15]}}, h};
        else
            return {{24{~uns & b[7]}}, b};
    endfunction

    // Overwrite the addressed byte/half of the read word with store data.
    function automatic logic [31:0] store_merge(
        input logic [31:0] word,
        input logic [15:0] wd,
        input logic        is_half,
        input logic [1:0]  lane
    );
        logic [31:0] m;
        m = word;
        if (is_half) begin
            if (lane[1]) m[31:16] = wd;
            else         m[15:0]  = wd;
        end else begin
            case (lane)
                2'd0:    m[7:0]   = wd[7:0];
                2'd1:    m[15:8]  = wd[7:0];
                2'd2:    m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end
        return m;
    endfunction

    assign w_accept      = bus.req_valid & r_req_ready;
    assign w_word_addr   = {{(32-MEM_ADDR_WIDTH){1'b0}}, bus.req_addr[MEM_ADDR_WIDTH+1:2]};
    // Address bits above the memory range alias and are deliberately ignored.
    assign w_unused_addr = ^bus.req_addr[31:MEM_ADDR_WIDTH+2];

    // Decode size, detect misalignment or force natural alignment of the lane.
    always_comb begin
        w_is_word  = bus.req_size[1];
        w_is_half  = (bus.req_size == 2'b01);
        w_lane     = bus.req_addr[1:0];
        w_misalign = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        w_misalign = (w_is_half & bus.req_addr[0]) |
                     (w_is_word & (bus.req_addr[1:0] != 2'b00));
`else
        if (w_is_word)
            w_lane = 2'b00;
        else if (w_is_half)
            w_lane[0] = 1'b0;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic: word stores write directly, everything else reads first.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misalign)
                        w_state_nxt = RESP;
                    else if (bus.req_we & w_is_word)
                        w_state_nxt = RMW_WR;
                    else
                        w_state_nxt = RD;
                end
            end
            RD:      w_state_nxt = RD_WAIT;
            RD_WAIT: w_state_nxt = r_we ? RMW_WR : RESP;
            RMW_WR:  w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake and write strobe registered from the next state so they are
    // glitch-free and all read 0 while reset is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_mem_rw    <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == IDLE);
            r_rsp_valid <= (w_state_nxt == RESP);
            r_mem_rw    <= (w_state_nxt == RMW_WR);
        end
    end

    // Capture request fields at accept; upstream may change them afterwards.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we      <= bus.req_we;
            r_uns     <= bus.req_unsigned;
            r_size    <= bus.req_size;
            r_lane    <= w_lane;
            r_wdata16 <= bus.req_wdata[15:0];
        end
    end

    // Memory address/data and response data; mem_addr holds between accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= w_misalign;
                        if (!w_misalign) begin
                            r_mem_addr <= w_word_addr;
                            if (bus.req_we & w_is_word)
                                r_mem_wdata <= bus.req_wdata;
                        end
                    end
                end
                RD_WAIT: begin
                    if (r_we)
                        r_mem_wdata <= store_merge(bus.mem_rdata, r_wdata16, r_size[0], r_lane);
                    else
                        r_rsp_rdata <= load_extract(bus.mem_rdata, r_size, r_lane, r_uns);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_rw    = r_mem_rw;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Testbench for lsu_mem_ctrl: directed vector table, hand-written multi-cycle
// sequences (backpressure, reset mid read-modify-write) and randomized
// traffic checked against a byte-lane reference model of the memory.
module tb_lsu_mem_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl #(.MEM_ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Single-port synchronous memory: read data valid one cycle after address.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.mem_rw === 1'b1)
            mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    end

    // Number of cycles with the write strobe high.
    int wr_count = 0;
    always @(posedge clk) begin
        if (bus.mem_rw === 1'b1)
            wr_count <= wr_count + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
    } vec_t;

`ifdef LSU_MISALIGN_CHECK_EN
    localparam logic [31:0] MIS_LW_RDATA = 32'h0000_0000;
    localparam logic        MIS_ERR      = 1'b1;
    localparam int          MIS_LD_LAT   = 1;
    localparam int          MIS_SH_LAT   = 1;
    localparam int          MIS_SH_WR    = 0;
    localparam logic [31:0] FINAL_WORD   = 32'h80EF_A544;
`else
    localparam logic [31:0] MIS_LW_RDATA = 32'hBEEF_A544;
    localparam logic        MIS_ERR      = 1'b0;
    localparam int          MIS_LD_LAT   = 3;
    localparam int          MIS_SH_LAT   = 4;
    localparam int          MIS_SH_WR    = 1;
    localparam logic [31:0] FINAL_WORD   = 32'h80EF_1357;
`endif

    function automatic vec_t mk(string nm, logic we, logic [1:0] sz, logic un,
                                logic [31:0] a, logic [31:0] wd, logic [31:0] er,
                                logic ee, int el, int ew);
        vec_t v;
        v.name = nm; v.we = we; v.size = sz; v.uns = un; v.addr = a; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_wr = ew;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Issue one request, hold rsp_ready low for 'hold' cycles once the response
    // is up, and check data, error, latency, write count and re-accept.
    task automatic do_vec(input vec_t v, input int hold);
        int cyc;
        int lat;
        int w0;
        bus.rsp_ready = 1'b0;
        cyc = 0;
        while (bus.req_ready !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({v.name, ":req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        if (bus.req_ready !== 1'b1) return;
        bus.req_valid    = 1'b1;
        bus.req_we       = v.we;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_addr     = v.addr;
        bus.req_wdata    = v.wdata;
        w0 = wr_count;
        @(posedge clk);
        #1;
        // Scramble the request fields: the DUT must use the captured copy.
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.rsp_valid !== 1'b1 && lat < 12);
        check({v.name, ":latency"}, lat, v.exp_lat);
        if (bus.rsp_valid !== 1'b1) return;
        for (int i = 0; i < hold; i++) begin
            check({v.name, ":hold_valid"}, {31'd0, bus.rsp_valid}, 32'd1);
            check({v.name, ":hold_rdata"}, bus.rsp_rdata, v.exp_rdata);
            check({v.name, ":hold_ready"}, {31'd0, bus.req_ready}, 32'd0);
            check({v.name, ":hold_mem_rw"}, {31'd0, bus.mem_rw}, 32'd0);
            @(negedge clk);
        end
        check({v.name, ":rdata"}, bus.rsp_rdata, v.exp_rdata);
        check({v.name, ":err"}, {31'd0, bus.rsp_err}, {31'd0, v.exp_err});
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check({v.name, ":writes"}, wr_count - w0, v.exp_wr);
        @(negedge clk);
        check({v.name, ":reaccept"}, {30'd0, bus.req_ready, bus.rsp_valid}, 32'd2);
    endtask

    // Reference model: 16 words at word index 0x180, addressed by byte lanes.
    logic [31:0] ref_mem [0:15];

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input int k, input int lane, input logic [19:0] hi,
                         input logic [31:0] wdata, output vec_t v);
        int nb;
        int eff;
        logic [31:0] val;
        logic [31:0] mask;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        eff = lane - (lane % nb);
        v = mk("rand", we, size, uns, {hi, 12'h600} + 32'(k * 4 + lane), wdata,
               32'd0, 1'b0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        if ((lane % nb) != 0) begin
            v.exp_err = 1'b1;
            v.exp_lat = 1;
            return;
        end
`endif
        if (we) begin
            mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1) << (8 * eff);
            ref_mem[k] = (ref_mem[k] & ~mask) | ((wdata << (8 * eff)) & mask);
            v.exp_lat = (nb == 4) ? 2 : 4;
            v.exp_wr  = 1;
        end else begin
            val = ref_mem[k] >> (8 * eff);
            if (nb == 1) begin
                val = val & 32'h0000_00FF;
                if (!uns && val[7]) val = val | 32'hFFFF_FF00;
            end else if (nb == 2) begin
                val = val & 32'h0000_FFFF;
                if (!uns && val[15]) val = val | 32'hFFFF_0000;
            end
            v.exp_rdata = val;
            v.exp_lat   = 3;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   w0;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst:req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst:rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst:rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rst:rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        check("rst:mem_addr",  bus.mem_addr, 32'd0);
        check("rst:mem_wdata", bus.mem_wdata, 32'd0);
        check("rst:mem_rw",    {31'd0, bus.mem_rw}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors
        tbl.push_back(mk("sw_dead",  1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0,        0, 2, 1));
        tbl.push_back(mk("lw_dead",  0, 2'd2, 0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 3, 0));
        tbl.push_back(mk("sw_1122",  1, 2'd2, 0, 32'h100, 32'h11223344, 32'h0,        0, 2, 1));
        tbl.push_back(mk("sb_a5",    1, 2'd0, 0, 32'h101, 32'h123456A5, 32'h0,        0, 4, 1));
        tbl.push_back(mk("lw_sb",    0, 2'd2, 0, 32'h100, 32'h0,        32'h1122A544, 0, 3, 0));
        tbl.push_back(mk("lb_a5",    0, 2'd0, 0, 32'h101, 32'h0,        32'hFFFFFFA5, 0, 3, 0));
        tbl.push_back(mk("lbu_a5",   0, 2'd0, 1, 32'h101, 32'h0,        32'h000000A5, 0, 3, 0));
        tbl.push_back(mk("sh_beef",  1, 2'd1, 0, 32'h102, 32'h9999BEEF, 32'h0,        0, 4, 1));
        tbl.push_back(mk("lw_sh",    0, 2'd2, 0, 32'h100, 32'h0,        32'hBEEFA544, 0, 3, 0));
        tbl.push_back(mk("lh_beef",  0, 2'd1, 0, 32'h102, 32'h0,        32'hFFFFBEEF, 0, 3, 0));
        tbl.push_back(mk("lhu_beef", 0, 2'd1, 1, 32'h102, 32'h0,        32'h0000BEEF, 0, 3, 0));
        tbl.push_back(mk("lw_mis",   0, 2'd2, 0, 32'h103, 32'h0,        MIS_LW_RDATA, MIS_ERR, MIS_LD_LAT, 0));
        tbl.push_back(mk("lw_alias", 0, 2'd2, 0, 32'h7FFFF100, 32'h0,   32'hBEEFA544, 0, 3, 0));
        tbl.push_back(mk("lsize3",   0, 2'd3, 1, 32'h100, 32'h0,        32'hBEEFA544, 0, 3, 0));
        tbl.push_back(mk("sb_80",    1, 2'd0, 0, 32'h103, 32'h00000080, 32'h0,        0, 4, 1));
        tbl.push_back(mk("lb_neg",   0, 2'd0, 0, 32'h103, 32'h0,        32'hFFFFFF80, 0, 3, 0));
        tbl.push_back(mk("lb_pos",   0, 2'd0, 0, 32'h100, 32'h0,        32'h00000044, 0, 3, 0));
        tbl.push_back(mk("lh_lo",    0, 2'd1, 0, 32'h100, 32'h0,        32'hFFFFA544, 0, 3, 0));
        tbl.push_back(mk("lb_ef",    0, 2'd0, 0, 32'h102, 32'h0,        32'hFFFFFFEF, 0, 3, 0));
        tbl.push_back(mk("sh_mis",   1, 2'd1, 0, 32'h101, 32'h00001357, 32'h0,        MIS_ERR, MIS_SH_LAT, MIS_SH_WR));
        tbl.push_back(mk("lw_final", 0, 2'd2, 0, 32'h100, 32'h0,        FINAL_WORD,   0, 3, 0));
        foreach (tbl[i]) do_vec(tbl[i], 0);

        // Response backpressure for 5 cycles
        do_vec(mk("lw_hold", 0, 2'd2, 0, 32'h100, 32'h0, FINAL_WORD, 0, 3, 0), 5);

        // Reset while a byte store sits in RD_WAIT
        do_vec(mk("sw_cafe", 1, 2'd2, 0, 32'h200, 32'hCAFEF00D, 32'h0, 0, 2, 1), 0);
        check("rmw_rst:req_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h201; bus.req_wdata = 32'h77;
        w0 = wr_count;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rmw_rst:req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rmw_rst:rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rmw_rst:rsp_rdata", bus.rsp_rdata, 32'd0);
        check("rmw_rst:rsp_err",   {31'd0, bus.rsp_err}, 32'd0);
        check("rmw_rst:mem_addr",  bus.mem_addr, 32'd0);
        check("rmw_rst:mem_wdata", bus.mem_wdata, 32'd0);
        check("rmw_rst:mem_rw",    {31'd0, bus.mem_rw}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rmw_rst:writes",    wr_count - w0, 32'd0);
        check("rmw_rst:no_rsp",    {31'd0, bus.rsp_valid}, 32'd0);
        do_vec(mk("lw_cafe", 0, 2'd2, 0, 32'h200, 32'h0, 32'hCAFEF00D, 0, 3, 0), 0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 16; k++) begin
            model(1'b1, 2'd2, 1'b0, k, 0, 20'($urandom), $urandom, v);
            do_vec(v, 0);
        end
        for (int n = 0; n < 300; n++) begin
            model(1'($urandom), 2'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), 20'($urandom), $urandom, v);
            do_vec(v, int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
